// File: rtl/alu_exec_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_exec_stage
//   Execute-stage wrapper around the external 16-bit ALU.
//   - E slot: holds the accepted op and drives the ALU combinationally.
//   - W slot: captures the ALU result for register-file writeback.
//   - Flags register: sources the ALU carry-in. It is updated when an op with
//     in_fwe set moves from E to W.
//   Optional feature macro: FLAGS_ZN_EN
//     - When defined, Z (bit2) and N (bit3) are also stored.
//     - When undefined, only C (bit0) and V (bit1) are stored.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake
//   in_a, in_b                operands
//   in_op                     opcode
//   in_rd                     destination register
//   in_fwe                    flag write enable
//   alu_a/b/op/ci             drive to ALU
//   alu_result/alu_flags      from ALU
//   wb_valid/wb_ready         downstream handshake
//   wb_result, wb_rd          writeback payload
//   flags_out                 current flags register
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int unsigned DATA_W = 32'd16,
  parameter int unsigned OP_W   = 32'd6,
  parameter int unsigned RD_W   = 32'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_fwe,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_ci,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [15:0]       alu_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_result,
  output logic [RD_W-1:0]   wb_rd,
  output logic [15:0]       flags_out
);

  logic              e_valid_r;
  logic [DATA_W-1:0] e_a_r;
  logic [DATA_W-1:0] e_b_r;
  logic [OP_W-1:0]   e_op_r;
  logic [RD_W-1:0]   e_rd_r;
  logic              e_fwe_r;

  logic              wb_valid_r;
  logic [DATA_W-1:0] wb_result_r;
  logic [RD_W-1:0]   wb_rd_r;
  logic [15:0]       flags_r;

  logic              e_adv_s;
  logic              accept_s;
  logic [15:0]       flags_next_s;
  logic              unused_flags_s;

  // The ALU reports only V/C in its low two bits; the upper bits are ignored.
  assign unused_flags_s = ^alu_flags[15:2];

  // Pipeline control.
  // E advances whenever W is empty or draining this cycle, so a new op can
  // enter E on the same edge the old one leaves (no bubble).
  always_comb begin
    e_adv_s  = e_valid_r && (!wb_valid_r || wb_ready);
    in_ready = !e_valid_r || e_adv_s;
    accept_s = in_valid && in_ready;
  end

  // Value written into the flags register when an E op with fwe advances.
  always_comb begin
`ifdef FLAGS_ZN_EN
    flags_next_s = {12'd0, alu_result[DATA_W-1],
                    (alu_result == {DATA_W{1'b0}}), alu_flags[1:0]};
`else
    flags_next_s = {14'd0, alu_flags[1:0]};
`endif
  end

  // E slot: load on accept, empty when its op leaves with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid_r <= 1'b0;
      e_a_r     <= {DATA_W{1'b0}};
      e_b_r     <= {DATA_W{1'b0}};
      e_op_r    <= {OP_W{1'b0}};
      e_rd_r    <= {RD_W{1'b0}};
      e_fwe_r   <= 1'b0;
    end else if (accept_s) begin
      e_valid_r <= 1'b1;
      e_a_r     <= in_a;
      e_b_r     <= in_b;
      e_op_r    <= in_op;
      e_rd_r    <= in_rd;
      e_fwe_r   <= in_fwe;
    end else if (e_adv_s) begin
      e_valid_r <= 1'b0;
    end
  end

  // W slot: capture the ALU output as E advances, release on downstream accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r  <= 1'b0;
      wb_result_r <= {DATA_W{1'b0}};
      wb_rd_r     <= {RD_W{1'b0}};
    end else if (e_adv_s) begin
      wb_valid_r  <= 1'b1;
      wb_result_r <= alu_result;
      wb_rd_r     <= e_rd_r;
    end else if (wb_valid_r && wb_ready) begin
      wb_valid_r  <= 1'b0;
    end
  end

  // Flags register.
  // It is written on the same edge the next op enters E, so a
  // dependent carry-in op needs no forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 16'd0;
    end else if (e_adv_s && e_fwe_r) begin
      flags_r <= flags_next_s;
    end
  end

  assign alu_a     = e_a_r;
  assign alu_b     = e_b_r;
  assign alu_op    = e_op_r;
  assign alu_ci    = flags_r[0];
  assign wb_valid  = wb_valid_r;
  assign wb_result = wb_result_r;
  assign wb_rd     = wb_rd_r;
  assign flags_out = flags_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
`timescale 1ns/1ps
// Testbench for alu_exec_stage.
// - Provides a behavioural ALU.
// - Checks writeback results, destination order and flags against a queue-based
//   reference model.
module tb_alu_exec_stage;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_ADDC = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SUBC = 6'd3;
  localparam logic [5:0] OP_BAD  = 6'd7;
`ifdef FLAGS_ZN_EN
  localparam logic [15:0] F_ADD_WRAP = 16'h0005;
`else
  localparam logic [15:0] F_ADD_WRAP = 16'h0001;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [5:0]  in_op;
  logic [2:0]  in_rd;
  logic        in_fwe;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_op;
  logic        alu_ci;
  logic [15:0] alu_result;
  logic [15:0] alu_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_result;
  logic [2:0]  wb_rd;
  logic [15:0] flags_out;

  alu_exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rd(in_rd), .in_fwe(in_fwe),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_result(wb_result), .wb_rd(wb_rd), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural ALU.
  // Returns {flags, result}.
  // - C is the carry for add and the borrow for subtract.
  // - V is signed overflow.
  // - Unknown opcodes return a ^ b with arbitrary flag bits.
  function automatic logic [31:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [5:0] op, input logic ci);
    int          sa;
    logic [15:0] r;
    logic        c;
    logic        v;
    sa = 0;
    case (op)
      OP_ADD, OP_ADDC: begin
        sa = int'(a) + int'(b) + ((op == OP_ADDC) ? int'(ci) : 0);
        r  = sa[15:0];
        c  = (sa > 65535);
        v  = (a[15] == b[15]) && (r[15] != a[15]);
        return {14'd0, v, c, r};
      end
      OP_SUB, OP_SUBC: begin
        sa = int'(a) - int'(b) - ((op == OP_SUBC) ? int'(ci) : 0);
        r  = sa[15:0];
        c  = (sa < 0);
        v  = (a[15] != b[15]) && (r[15] != a[15]);
        return {14'd0, v, c, r};
      end
      default: return {a[13:0], b[1:0], a ^ b};
    endcase
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_op, alu_ci);

  // Flag value that the stage should keep after an fwe op with result r and ALU flags f.
  function automatic logic [15:0] keep_flags(input logic [15:0] r, input logic [15:0] f);
`ifdef FLAGS_ZN_EN
    return {12'd0, r[15], (r == 16'd0), f[1:0]};
`else
    return {14'd0, f[1:0]};
`endif
  endfunction

  // Reference model state: expected writebacks in acceptance order.
  logic [15:0] exp_res_q[$];
  logic [2:0]  exp_rd_q[$];
  logic [15:0] exp_fl_q[$];
  logic [15:0] m_flags = 16'd0;
  logic [31:0] m_fr;
  logic [15:0] last_result;
  logic [15:0] last_flags;
  int          wb_count   = 0;
  logic        stall_seen = 1'b0;

  // Monitor.
  // Inputs are stable from the falling edge to the next rising edge, so what is
  // seen here is exactly what transfers on that rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && !in_ready) stall_seen = 1'b1;
      if (wb_valid && wb_ready) begin
        if (exp_res_q.size() == 0) begin
          chk("wb_unexpected", 32'd1, 32'd0);
        end else begin
          chk("wb_result", {16'd0, wb_result}, {16'd0, exp_res_q.pop_front()});
          chk("wb_rd", {29'd0, wb_rd}, {29'd0, exp_rd_q.pop_front()});
          chk("flags_out", {16'd0, flags_out}, {16'd0, exp_fl_q.pop_front()});
        end
        last_result = wb_result;
        last_flags  = flags_out;
        wb_count++;
      end
      if (in_valid && in_ready) begin
        m_fr = alu_model(in_a, in_b, in_op, m_flags[0]);
        if (in_fwe) m_flags = keep_flags(m_fr[15:0], m_fr[31:16]);
        exp_res_q.push_back(m_fr[15:0]);
        exp_rd_q.push_back(in_rd);
        exp_fl_q.push_back(m_flags);
      end
    end
  end

  logic rnd_wb = 1'b0;

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op,
                      input logic [2:0] rd, input logic fwe);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_rd = rd; in_fwe = fwe;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rnd_wb) wb_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) begin
      chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
    @(posedge clk); #1;
    if (rnd_wb) wb_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_wb(input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wb_count >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("wb_timeout", 32'd0, 32'd1);
  endtask

  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; in_op = 6'd0;
    in_rd = 3'd0; in_fwe = 1'b0; wb_ready = 1'b1;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_flags", {16'd0, flags_out}, 32'd0);
    chk("rst_wb_result", {16'd0, wb_result}, 32'd0);
    chk("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD wrap with two-cycle latency.
    base = wb_count;
    send(16'hFFFF, 16'h0001, OP_ADD, 3'd1, 1'b1);
    in_valid = 1'b0;
    chk("t1_lat_early", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t1_lat", {31'd0, wb_valid}, 32'd1);
    wait_wb(base + 1);
    chk("t1_res", {16'd0, last_result}, 32'h0000);
    chk("t1_flags", {16'd0, last_flags}, {16'd0, F_ADD_WRAP});

    // ADD(fwe) then ADDC back to back sees the new carry.
    base = wb_count;
    send(16'hFFFF, 16'h0001, OP_ADD, 3'd2, 1'b1);
    send(16'h0000, 16'h0000, OP_ADDC, 3'd3, 1'b1);
    in_valid = 1'b0;
    wait_wb(base + 2);
    chk("t2_res", {16'd0, last_result}, 32'h0001);
    chk("t2_flags", {16'd0, last_flags}, 32'h0000);

    // SUB overflow, then flags held by ops without fwe.
    base = wb_count;
    send(16'h8000, 16'h0001, OP_SUB, 3'd4, 1'b1);
    in_valid = 1'b0;
    wait_wb(base + 1);
    chk("t3_res", {16'd0, last_result}, 32'h7FFF);
    chk("t3_flags", {16'd0, last_flags}, 32'h0002);
    send(16'h8000, 16'h0001, OP_SUB, 3'd4, 1'b0);
    send(16'h0000, 16'h0000, OP_ADD, 3'd5, 1'b0);
    in_valid = 1'b0;
    wait_wb(base + 3);
    chk("t3_nofwe_res", {16'd0, last_result}, 32'h0000);
    chk("t3_nofwe_flags", {16'd0, last_flags}, 32'h0002);

    // Four ops into a stalled writeback port.
    base = wb_count;
    wb_ready = 1'b0;
    stall_seen = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 wb_ready = 1'b1;
      end
    join_none
    send(16'd10, 16'd1, OP_ADD, 3'd0, 1'b0);
    send(16'd20, 16'd2, OP_SUB, 3'd1, 1'b0);
    send(16'd30, 16'd3, OP_ADD, 3'd2, 1'b0);
    send(16'd40, 16'd4, OP_SUB, 3'd3, 1'b0);
    in_valid = 1'b0;
    wait_wb(base + 4);
    chk("t4_stall_seen", {31'd0, stall_seen}, 32'd1);
    chk("t4_last", {16'd0, last_result}, 32'd36);

    // Reset with E and W both full.
    wb_ready = 1'b0;
    send(16'hFFFF, 16'h0001, OP_ADD, 3'd5, 1'b1);
    send(16'h0001, 16'h0002, OP_ADD, 3'd6, 1'b1);
    in_valid = 1'b0;
    chk("t5_pre_full", {30'd0, wb_valid, in_ready}, 32'd2);
    chk("t5_pre_flags", {16'd0, flags_out}, {16'd0, F_ADD_WRAP});
    rst = 1'b1;
    exp_res_q.delete(); exp_rd_q.delete(); exp_fl_q.delete();
    m_flags = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    chk("t5_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("t5_flags", {16'd0, flags_out}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    base = wb_count;
    send(16'h0001, 16'h0001, OP_ADDC, 3'd7, 1'b1);
    in_valid = 1'b0;
    wait_wb(base + 1);
    chk("t5_addc", {16'd0, last_result}, 32'h0002);

    // Random stream under random back-pressure.
    rnd_wb = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [5:0]  rop;
      ra = $urandom_range(0, 65535);
      rb = $urandom_range(0, 65535);
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = 16'h8000;
      case ($urandom_range(0, 4))
        0:       rop = OP_ADD;
        1:       rop = OP_ADDC;
        2:       rop = OP_SUB;
        3:       rop = OP_SUBC;
        default: rop = OP_BAD;
      endcase
      send(ra, rb, rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        wb_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rnd_wb = 1'b0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_res_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_res_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
